// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with registered read ports and a stall hold.
// Optional write-to-read bypass on the registered ports: define REGFILE_BYPASS_EN.
module regfile_2r1w #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [4:0]       ra_addr,
  input  logic [4:0]       rb_addr,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] ra_data,
  output logic [WIDTH-1:0] rb_data,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic             wr_live;

  assign wr_live = wr_en && (wr_addr != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_live) regs_d[wr_addr] = wr_data;
    regs_d[0] = '0;
  end

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (ra_addr != 5'd0) rd_a = regs_q[ra_addr];
    if (rb_addr != 5'd0) rd_b = regs_q[rb_addr];
`ifdef REGFILE_BYPASS_EN
    // Same-cycle write is forwarded so the port sees the value being written.
    if (wr_live && (wr_addr == ra_addr)) rd_a = wr_data;
    if (wr_live && (wr_addr == rb_addr)) rd_b = wr_data;
`endif
    ra_d = stall ? ra_q : rd_a;
    rb_d = stall ? rb_q : rd_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      ra_q <= '0;
      rb_q <= '0;
    end else begin
      regs_q <= regs_d;
      ra_q   <= ra_d;
      rb_q   <= rb_d;
    end
  end

  assign ra_data  = ra_q;
  assign rb_data  = rb_q;
  // Debug view is the stored array only: no bypass, no stall.
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter: WIDTH, 32, data width of every register and data port.
REQ-002 Parameter: DEPTH, 32, number of registers, fixed to match the 5-bit address ports.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: stall  input  1  holds both registered read outputs when high.
REQ-006 Port: ra_addr  input  5  read port A register index.
REQ-007 Port: rb_addr  input  5  read port B register index.
REQ-008 Port: wr_en  input  1  write enable.
REQ-009 Port: wr_addr  input  5  write register index.
REQ-010 Port: wr_data  input  WIDTH  write data.
REQ-011 Port: ra_data  output  WIDTH  registered read data, port A.
REQ-012 Port: rb_data  output  WIDTH  registered read data, port B.
REQ-013 Port: dbg_addr  input  5  debug read index.
REQ-014 Port: dbg_data  output  WIDTH  combinational debug read of stored array.

Function
REQ-015 Storage SHALL be 32 x WIDTH registers; register 0 SHALL always read as 0.
REQ-016 On a rising edge with wr_en=1 and wr_addr!=0, reg[wr_addr] SHALL take wr_data; writes to index 0 SHALL be discarded.
REQ-017 Read latency SHALL be exactly one cycle: addresses presented in cycle N produce data on ra_data/rb_data from cycle N+1.
REQ-018 On a rising edge with stall=0, ra_data SHALL load the read value for ra_addr and rb_data the read value for rb_addr.
REQ-019 On a rising edge with stall=1, ra_data and rb_data SHALL hold; writes SHALL still complete.
REQ-020 Both read ports SHALL be independent; ra_addr==rb_addr SHALL return identical data on both.
REQ-021 Simultaneous write and read of the same nonzero index: the read value SHALL follow REQ-030/REQ-031.
REQ-022 A read of index 0 SHALL load 0 regardless of wr_en/wr_addr/wr_data.
REQ-023 dbg_data SHALL equal the stored value of reg[dbg_addr] (0 for index 0) combinationally, with no bypass and no stall effect.

Reset
REQ-024 With rst=1 at a rising edge, all 32 registers, ra_data and rb_data SHALL become 0.
REQ-025 rst SHALL take priority over wr_en and stall in the same cycle; a write coincident with rst SHALL be lost.
REQ-026 rst asserted mid-stream SHALL discard pending read results; the first cycle after rst deasserts SHALL behave as a normal cycle.
REQ-027 dbg_data SHALL read 0 for every index in the cycle after reset.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN SHALL select write-to-read bypass at compile time.
REQ-029 Bypass SHALL apply only to ra_data/rb_data, never to dbg_data.
REQ-030 With REGFILE_BYPASS_EN defined: when wr_en=1, wr_addr!=0 and wr_addr equals a read address in the same cycle, that port SHALL load wr_data.
REQ-031 Without REGFILE_BYPASS_EN: that port SHALL load the previously stored value; the new value SHALL be visible on the next read.

Verification
REQ-032 Reset then read all 32 indices on both ports -> every ra_data/rb_data and dbg_data value 0.
REQ-033 Write 0xDEADBEEF to index 0, read index 0 next cycle -> ra_data=0, dbg_data=0.
REQ-034 Write 0x12345678 to index 5 in cycle N, ra_addr=5 in cycle N+1 -> ra_data=0x12345678 in cycle N+2.
REQ-035 Index 7 holds 0x11111111; write 0x22222222 to 7 with ra_addr=rb_addr=7 in same cycle -> both 0x22222222 with REGFILE_BYPASS_EN, 0x11111111 without.
REQ-036 ra_data=0xAAAA0000 loaded; stall=1 for 3 cycles while writing 0x55555555 to that index and changing ra_addr -> ra_data holds 0xAAAA0000; dbg_data shows 0x55555555; after stall=0 ra_data follows new ra_addr.
REQ-037 rst=1 coincident with wr_en=1, wr_addr=9, wr_data=0xCAFEF00D -> reg 9 reads 0 after reset.
